// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: register scoreboard with RAW hazard stall, one-cycle flush/redirect
// broadcast and a sticky halt latch for the in-order core.
module pipeline_ctrl #(
  parameter int NUM_REGS   = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ADDR_W     = 32,
  parameter int KILL_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dec_valid,
  input  logic [REG_ADDR_W-1:0] dec_rs1_addr,
  input  logic [REG_ADDR_W-1:0] dec_rs2_addr,
  input  logic                  dec_rs1_used,
  input  logic                  dec_rs2_used,
  input  logic [REG_ADDR_W-1:0] dec_rd_addr,
  input  logic                  dec_rd_we,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd_addr,
  input  logic                  wb_rd_we,
  input  logic                  ex_flush,
  input  logic [ADDR_W-1:0]     ex_flush_addr,
  input  logic                  ex_halt,
  input  logic                  mem_stall,
  output logic                  stall_pipe,
  output logic                  stall_decode,
  output logic                  flush,
  output logic                  redirect_valid,
  output logic [ADDR_W-1:0]     redirect_addr,
  output logic                  halted,
  output logic [NUM_REGS-1:0]   pending
);

  typedef enum logic [1:0] {RUN, FLUSH, HALTED} state_t;
  state_t state;

  logic                  rs1_hit;
  logic                  rs2_hit;
  logic                  hazard;
  logic                  issue;
  logic                  push_valid;
  logic                  wb_clear;
  logic                  flush_take;
  logic                  halt_take;
  logic [NUM_REGS-1:0]   pending_next;
  logic [KILL_DEPTH-1:0] kill_valid;
  logic [REG_ADDR_W-1:0] kill_rd [KILL_DEPTH];

  assign rs1_hit      = dec_rs1_used && (dec_rs1_addr != '0) && pending[dec_rs1_addr];
  assign rs2_hit      = dec_rs2_used && (dec_rs2_addr != '0) && pending[dec_rs2_addr];
  assign hazard       = dec_valid && (rs1_hit || rs2_hit);
  assign stall_pipe   = mem_stall || (state == HALTED);
  assign stall_decode = hazard || stall_pipe || (state == FLUSH);
  assign issue        = dec_valid && !stall_decode && !ex_flush;
  assign push_valid   = issue && dec_rd_we && (dec_rd_addr != '0);
  assign wb_clear     = wb_valid && wb_rd_we && (wb_rd_addr != '0);
  assign halt_take    = ex_halt && (state != HALTED);
  assign flush_take   = ex_flush && !ex_halt && (state != HALTED);

  // Issue-set is applied last so it wins over a same-cycle writeback or kill.
  always_comb begin
    pending_next = pending;
    if (wb_clear) pending_next[wb_rd_addr] = 1'b0;
    if (flush_take) begin
      for (int i = 0; i < KILL_DEPTH; i++) begin
        if (kill_valid[i]) pending_next[kill_rd[i]] = 1'b0;
      end
    end
    if (push_valid) pending_next[dec_rd_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending    <= '0;
      kill_valid <= '0;
      for (int i = 0; i < KILL_DEPTH; i++) kill_rd[i] <= '0;
    end else begin
      pending <= pending_next;
      if (flush_take) begin
        kill_valid <= '0;
      end else if (!stall_pipe) begin
        kill_valid[0] <= push_valid;
        kill_rd[0]    <= dec_rd_addr;
        for (int i = 1; i < KILL_DEPTH; i++) begin
          kill_valid[i] <= kill_valid[i-1];
          kill_rd[i]    <= kill_rd[i-1];
        end
      end
    end
  end

  // A halt outranks a simultaneous flush and is only undone by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= RUN;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_addr  <= '0;
      halted         <= 1'b0;
    end else begin
      flush          <= flush_take;
      redirect_valid <= flush_take;
      if (flush_take) redirect_addr <= ex_flush_addr;
      case (state)
        RUN, FLUSH: begin
          if (halt_take) begin
            state  <= HALTED;
            halted <= 1'b1;
          end else if (ex_flush) begin
            state <= FLUSH;
          end else begin
            state <= RUN;
          end
        end
        HALTED:  state <= HALTED;
        default: state <= RUN;
      endcase
    end
  end

endmodule
